// File: rtl/t_pulse_conditioner.sv
// t_pulse_conditioner: turns a raw bouncing button input into clean single-cycle
// toggle pulses. The path is a synchronizer chain, then a debounce FSM, then an
// optional hold-to-repeat pulse generator. It also exports the debounced level
// and a wrapping count of the pulses issued.
module t_pulse_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_CYCLES   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic       t_out,
    output logic       btn_level,
    output logic [7:0] pulse_cnt
);

    localparam int CNT_W      = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int REP_W      = $clog2(REPEAT_CYCLES) + 1;
    localparam bit REP_EN     = (REPEAT_CYCLES > 0);
    localparam int REP_LAST_I = REP_EN ? REPEAT_CYCLES - 1 : 0;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REP_LAST_I);
    localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_CHK   = 2'd1,
        HELD        = 2'd2,
        RELEASE_CHK = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_sync;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [REP_W-1:0]       rep_cnt_q, rep_cnt_d;
    logic                   t_q, t_d;
    logic                   level_q, level_d;
    logic [7:0]             pulse_cnt_q, pulse_cnt_d;

    assign btn_sync = sync_q[SYNC_STAGES-1];

    // Synchronizer chain: the FSM only ever looks at the last stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
    end

    // Debounce FSM and repeat generator next-state logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rep_cnt_d = rep_cnt_q;
        level_d   = level_q;
        t_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (btn_sync) begin
                    state_d = PRESS_CHK;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_CHK: begin
                if (!btn_sync) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = HELD;
                    level_d   = 1'b1;
                    t_d       = 1'b1;
                    rep_cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (!btn_sync) begin
                    state_d = RELEASE_CHK;
                    cnt_d   = CNT_ONE;
                end else if (REP_EN) begin
                    if (rep_cnt_q == REP_LAST) begin
                        t_d       = 1'b1;
                        rep_cnt_d = '0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + REP_ONE;
                    end
                end
            end
            RELEASE_CHK: begin
                // A glitch back to 1 resumes HELD with the repeat phase frozen.
                if (btn_sync) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    level_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pulse counter advances at the end of each cycle in which t_out is high.
    always_comb begin
        pulse_cnt_d = pulse_cnt_q + {7'd0, t_q};
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rep_cnt_q   <= '0;
            t_q         <= 1'b0;
            level_q     <= 1'b0;
            pulse_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            t_q         <= t_d;
            level_q     <= level_d;
            pulse_cnt_q <= pulse_cnt_d;
        end
    end

    assign t_out     = t_q;
    assign btn_level = level_q;
    assign pulse_cnt = pulse_cnt_q;

endmodule

// File: doc/t_pulse_conditioner.md
# t_pulse_conditioner

Converts a raw, asynchronous, bouncing push-button or switch input into clean single-cycle toggle pulses. It sits directly upstream of the toggle flip-flop and drives that flip-flop's `t` input, so one physical press produces exactly one toggle. The block contains a synchronizer, a debounce state machine and an optional hold-to-repeat generator. It also exports the debounced level and a running pulse count for status and debug.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: number of synchronizer flops on `btn_in`. Legal values are ≥2.
- `DEBOUNCE_CYCLES`, default 4: consecutive stable samples required to accept a level change. Legal values are ≥2.
- `REPEAT_CYCLES`, default 0: pulse period, in cycles, while the button is held. 0 disables repeat. Legal values are 0 or ≥2.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `btn_in`  in  1  raw asynchronous input; 1 means pressed.
- `t_out`  out  1  toggle pulse, high for exactly one cycle per accepted event; connects to the flip-flop's `t`.
- `btn_level`  out  1  debounced, registered button level.
- `pulse_cnt`  out  8  count of `t_out` pulses issued, modulo 256.

## Operation
- Synchronizer: `btn_in` passes through a chain of `SYNC_STAGES` flops. The last stage is `btn_sync`, and the FSM reads only `btn_sync`.
- Debounce counter `cnt` has width clog2(`DEBOUNCE_CYCLES`)+1. Repeat counter `rep_cnt` has width clog2(`REPEAT_CYCLES`)+1, with a minimum of 1.
- FSM states are IDLE, PRESS_CHK, HELD and RELEASE_CHK.
- IDLE (`btn_level`=0):
  - If `btn_sync`=1, go to PRESS_CHK and set `cnt`←1.
- PRESS_CHK:
  - If `btn_sync`=0, go to IDLE and set `cnt`←0. No pulse.
  - Otherwise, if `cnt`=`DEBOUNCE_CYCLES`−1, go to HELD. Set `btn_level`←1, pulse `t_out`, and set `rep_cnt`←0.
  - Otherwise, `cnt`++.
- HELD (`btn_level`=1):
  - If `btn_sync`=0, go to RELEASE_CHK and set `cnt`←1.
  - Otherwise, if `REPEAT_CYCLES`>0, `rep_cnt` increments. When `rep_cnt`=`REPEAT_CYCLES`−1, pulse `t_out` and set `rep_cnt`←0.
- RELEASE_CHK:
  - If `btn_sync`=1, return to HELD. `rep_cnt` stays frozen at its value and does not reset.
  - Otherwise, if `cnt`=`DEBOUNCE_CYCLES`−1, go to IDLE and set `btn_level`←0. No pulse on release.
  - Otherwise, `cnt`++.
  - No repeat pulses are issued in RELEASE_CHK.
- `pulse_cnt` increments on every cycle in which `t_out`=1. It wraps from 255 to 0 with no flag.
- `t_out` is registered and never stays high for two consecutive cycles, because `REPEAT_CYCLES`≥2.

## Timing
- Reset values: all synchronizer flops 0, state IDLE, `cnt`=0, `rep_cnt`=0, `t_out`=0, `btn_level`=0, `pulse_cnt`=0.
- Reset takes effect immediately and asynchronously; release of reset is synchronous to `clk`.
- Press latency: let edge 1 be the first rising edge that samples `btn_in`=1. `t_out` and `btn_level` go high after edge `SYNC_STAGES`+`DEBOUNCE_CYCLES`. With defaults, that is edge 6, provided `btn_in` stays high throughout.
- Release latency: `btn_level` falls after edge `SYNC_STAGES`+`DEBOUNCE_CYCLES`, counted from the first edge that samples `btn_in`=0.
- Repeat: the first repeat pulse comes `REPEAT_CYCLES` cycles after the press pulse. Later pulses follow every `REPEAT_CYCLES` cycles.
- Bounce: any `btn_sync` run shorter than `DEBOUNCE_CYCLES` samples is rejected with no output change.
- Reset mid-press or mid-hold: outputs clear at once. If `btn_in` is still high after reset is released, the block re-debounces and issues a new press pulse after the full press latency.

## Test plan
1. Reset, then hold `btn_in`=1 for 20 cycles with defaults -> exactly one `t_out` pulse, after edge 6; `btn_level`=1; `pulse_cnt`=1.
2. Bounce `btn_in` with high runs of 1, 2 and 3 cycles separated by 1-cycle lows -> no `t_out`, `btn_level` stays 0; a following 4-cycle-stable high -> one pulse.
3. `REPEAT_CYCLES`=5, hold for 30 cycles after the first pulse -> press pulse plus repeat pulses every 5 cycles (6 repeats); `pulse_cnt`=7.
4. While HELD, drop `btn_in` to 0 for 2 cycles and then back to 1 -> `btn_level` stays 1 and no extra pulse occurs. A later 4+ cycle low -> `btn_level`=0 and no pulse.
5. Assert `rst` while in HELD with `btn_in` held at 1 -> `t_out`, `btn_level` and `pulse_cnt` read 0 immediately. After reset is released -> one new pulse at latency 6.
6. Issue 257 press/release cycles -> `pulse_cnt` wraps and reads 1, and a downstream toggle flip-flop's `q` is 1 (odd pulse count).
